// File: rtl/accel_spi_reader.sv
// ============================================================================
// accel_spi_reader : configures a 3-axis SPI accelerometer, then polls X/Y.
// Revision: 1.0
// ============================================================================
`default_nettype none

module accel_spi_reader #(
   parameter int          SCLK_HALF   = 1,
   parameter int          POLL_PERIOD = 10000,
   parameter logic [7:0]  FMT_VAL     = 8'h08,
   parameter logic [7:0]  PWR_VAL     = 8'h08
) (
   input  logic        btn_clk,
   input  logic        arst_n,
   output logic        spi_cs_n,
   output logic        spi_sclk,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic [15:0] accel_data_x,
   output logic [15:0] accel_data_y,
   output logic        accel_valid,
   output logic        init_done
);

   localparam int             PW          = $clog2(POLL_PERIOD + 1);
   localparam logic [PW-1:0]  c_poll_last = PW'(POLL_PERIOD - 1);
   localparam logic [4:0]     c_half_last = 5'(SCLK_HALF - 1);
   localparam logic [4:0]     c_gap_last  = 5'(2 * SCLK_HALF - 1);

   typedef enum logic [2:0] {
      S_INIT_FMT, S_INIT_PWR, S_WAIT_POLL, S_READ, S_UPDATE
   } state_t;

   typedef enum logic [2:0] {
      P_IDLE, P_SETUP, P_LOW, P_HIGH, P_GAP
   } phase_t;

   state_t         r_state, w_state_nxt;
   phase_t         r_phase, w_phase_nxt;
   logic [4:0]     r_cnt;
   logic [5:0]     r_bit;
   logic [5:0]     r_nbits;
   logic [39:0]    r_tx;
   logic [31:0]    r_rx;
   logic           r_cs_n, r_sclk, r_mosi;
   logic [15:0]    r_x, r_y;
   logic           r_valid, r_init_done;
   logic [PW-1:0]  r_poll;

   logic           w_start, w_half_end, w_gap_end, w_last_bit, w_xfer_end, w_wrap;
   logic [39:0]    w_tx_word;
   logic [5:0]     w_tx_bits;

   assign w_half_end = (r_cnt == c_half_last);
   assign w_gap_end  = (r_cnt == c_gap_last);
   assign w_last_bit = (r_bit == r_nbits - 6'd1);
   assign w_xfer_end = (r_phase == P_HIGH) && w_half_end && w_last_bit;
   assign w_wrap     = r_init_done && (r_poll == c_poll_last);

   always_ff @(posedge btn_clk) begin
      if (!arst_n) begin
         r_state <= S_INIT_FMT;
         r_phase <= P_IDLE;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
      end
   end

   // Each transaction-issuing state starts the engine only once it is idle,
   // which also enforces the CS_n high gap between back-to-back transfers.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_tx_word   = '0;
      w_tx_bits   = 6'd40;
      case (r_state)
         S_INIT_FMT: begin
            w_tx_word = {8'h31, FMT_VAL, 24'h0};
            w_tx_bits = 6'd16;
            w_start   = (r_phase == P_IDLE);
            if (w_xfer_end) w_state_nxt = S_INIT_PWR;
         end
         S_INIT_PWR: begin
            w_tx_word = {8'h2D, PWR_VAL, 24'h0};
            w_tx_bits = 6'd16;
            w_start   = (r_phase == P_IDLE);
            if (w_xfer_end) w_state_nxt = S_WAIT_POLL;
         end
         S_WAIT_POLL: begin
            if (w_wrap) w_state_nxt = S_READ;
         end
         S_READ: begin
            w_tx_word = {8'hF2, 32'h0};
            w_start   = (r_phase == P_IDLE);
            if (w_xfer_end) w_state_nxt = S_UPDATE;
         end
         S_UPDATE: w_state_nxt = S_WAIT_POLL;
         default:  w_state_nxt = S_INIT_FMT;
      endcase
   end

   always_comb begin
      w_phase_nxt = r_phase;
      case (r_phase)
         P_IDLE:  if (w_start)   w_phase_nxt = P_SETUP;
         P_SETUP: if (w_half_end) w_phase_nxt = P_LOW;
         P_LOW:   if (w_half_end) w_phase_nxt = P_HIGH;
         P_HIGH:  if (w_half_end) w_phase_nxt = w_last_bit ? P_GAP : P_LOW;
         P_GAP:   if (w_gap_end)  w_phase_nxt = P_IDLE;
         default: w_phase_nxt = P_IDLE;
      endcase
   end

   always_ff @(posedge btn_clk) begin
      if (!arst_n) begin
         r_cnt   <= '0;
         r_bit   <= '0;
         r_nbits <= '0;
         r_tx    <= '0;
         r_rx    <= '0;
         r_cs_n  <= 1'b1;
         r_sclk  <= 1'b1;
         r_mosi  <= 1'b0;
      end else begin
         case (r_phase)
            P_IDLE: begin
               r_cnt <= '0;
               if (w_start) begin
                  r_cs_n  <= 1'b0;
                  r_bit   <= '0;
                  r_nbits <= w_tx_bits;
                  r_tx    <= w_tx_word;
               end
            end
            P_SETUP: begin
               if (w_half_end) begin
                  r_cnt  <= '0;
                  r_sclk <= 1'b0;
                  r_mosi <= r_tx[39];
                  r_tx   <= {r_tx[38:0], 1'b0};
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            P_LOW: begin
               if (w_half_end) begin
                  r_cnt  <= '0;
                  r_sclk <= 1'b1;
                  r_rx   <= {r_rx[30:0], spi_miso};
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            P_HIGH: begin
               if (w_half_end) begin
                  r_cnt <= '0;
                  if (w_last_bit) begin
                     r_cs_n <= 1'b1;
                     r_mosi <= 1'b0;
                  end else begin
                     r_sclk <= 1'b0;
                     r_mosi <= r_tx[39];
                     r_tx   <= {r_tx[38:0], 1'b0};
                     r_bit  <= r_bit + 6'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            P_GAP:   r_cnt <= w_gap_end ? 5'd0 : r_cnt + 5'd1;
            default: r_cnt <= '0;
         endcase
      end
   end

   // After a read the last 32 captured bits are X0,X1,Y0,Y1 from MSB down.
   always_ff @(posedge btn_clk) begin
      if (!arst_n) begin
         r_x         <= '0;
         r_y         <= '0;
         r_valid     <= 1'b0;
         r_init_done <= 1'b0;
         r_poll      <= '0;
      end else begin
         r_valid <= (r_state == S_UPDATE);
         if (r_state == S_UPDATE) begin
            r_x <= {r_rx[23:16], r_rx[31:24]};
            r_y <= {r_rx[7:0],   r_rx[15:8]};
         end
         if ((r_state == S_INIT_PWR) && w_xfer_end) r_init_done <= 1'b1;
         if (!r_init_done || (r_poll == c_poll_last)) r_poll <= '0;
         else                                          r_poll <= r_poll + 1'b1;
      end
   end

   assign spi_cs_n     = r_cs_n;
   assign spi_sclk     = r_sclk;
   assign spi_mosi     = r_mosi;
   assign accel_data_x = r_x;
   assign accel_data_y = r_y;
   assign accel_valid  = r_valid;
   assign init_done    = r_init_done;

endmodule

`default_nettype wire

// File: tb/tb_accel_spi_reader.sv
// ============================================================================
// tb_accel_spi_reader : directed bench with an SPI mode-3 slave and monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_accel_spi_reader;

   localparam int SH = 2;
   localparam int PP = 10000;

   logic        btn_clk = 1'b0;
   logic        arst_n  = 1'b0;
   logic        spi_miso = 1'b0;
   logic        spi_cs_n, spi_sclk, spi_mosi;
   logic [15:0] accel_data_x, accel_data_y;
   logic        accel_valid, init_done;

   always #5 btn_clk = ~btn_clk;

   accel_spi_reader #(.SCLK_HALF(SH), .POLL_PERIOD(PP), .FMT_VAL(8'h08), .PWR_VAL(8'h08)) dut (
      .btn_clk(btn_clk), .arst_n(arst_n),
      .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .accel_data_x(accel_data_x), .accel_data_y(accel_data_y),
      .accel_valid(accel_valid), .init_done(init_done)
   );

   int tests = 0;
   int fails = 0;

   logic [39:0] slave_tx = '0;
   logic [39:0] tr_mosi[$];
   int          tr_bits[$], tr_falls[$], tr_tfall[$];
   logic        tr_init[$], tr_init_pre[$];
   int          read_idx[$];

   logic [39:0] cur_mosi = '0;
   int cur_bits = 0, cur_falls = 0, cur_tfall = 0;
   int mcyc = 0, run = 0, cs_hi_run = 100, last_rise = 0;
   int valid_cnt = 0, valid_delta = 0;
   int viol_phase = 0, viol_gap = 0, viol_idle = 0, viol_mosi = 0, viol_valid2 = 0;
   logic p_cs = 1'b1, p_sclk = 1'b1, p_mosi = 1'b0, p_valid = 1'b0, p_init = 1'b0;

   // Sampling monitor plus mode-3 slave: MISO changes after each SCLK fall.
   always @(posedge btn_clk) begin
      #1;
      mcyc++;
      if (!spi_cs_n && p_cs) begin
         cur_mosi = '0; cur_bits = 0; cur_falls = 0; cur_tfall = mcyc;
         if (cs_hi_run < 2*SH) viol_gap++;
      end
      if (spi_cs_n) cs_hi_run++; else cs_hi_run = 0;
      if (!spi_cs_n && p_sclk && !spi_sclk) begin
         spi_miso = (cur_falls < 40) ? slave_tx[39 - cur_falls] : 1'b0;
         cur_falls++;
      end
      if (!spi_cs_n && !p_sclk && spi_sclk) begin
         cur_mosi = {cur_mosi[38:0], spi_mosi};
         cur_bits++;
      end
      if (spi_cs_n && !p_cs) begin
         tr_mosi.push_back(cur_mosi);  tr_bits.push_back(cur_bits);
         tr_falls.push_back(cur_falls); tr_tfall.push_back(cur_tfall);
         tr_init.push_back(init_done); tr_init_pre.push_back(p_init);
         if (cur_bits == 40) read_idx.push_back(tr_mosi.size() - 1);
         last_rise = mcyc;
         spi_miso  = 1'b0;
      end
      if ((spi_cs_n != p_cs) || (spi_sclk != p_sclk)) begin
         if (arst_n && !p_cs && run != SH) viol_phase++;
         run = 1;
      end else begin
         run++;
      end
      if (spi_cs_n && (!spi_sclk || spi_mosi)) viol_idle++;
      if (arst_n && !spi_cs_n && !p_cs && (spi_mosi != p_mosi) && !(p_sclk && !spi_sclk)) viol_mosi++;
      if (accel_valid) begin
         if (p_valid) viol_valid2++;
         valid_cnt++;
         valid_delta = mcyc - last_rise;
      end
      p_cs = spi_cs_n; p_sclk = spi_sclk; p_mosi = spi_mosi;
      p_valid = accel_valid; p_init = init_done;
   end

   task automatic wait_tr(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge btn_clk); #2;
         if (tr_mosi.size() >= n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      repeat (3) @(posedge btn_clk);
      #2;
      tests++;
      if ({spi_cs_n, spi_sclk, spi_mosi, accel_valid, init_done} !== 5'b11000) begin
         fails++; $display("FAIL reset_ctrl got %b want 11000", {spi_cs_n, spi_sclk, spi_mosi, accel_valid, init_done});
      end
      tests++;
      if (accel_data_x !== 16'h0) begin fails++; $display("FAIL reset_x got %h want 0000", accel_data_x); end
      tests++;
      if (accel_data_y !== 16'h0) begin fails++; $display("FAIL reset_y got %h want 0000", accel_data_y); end
   endtask

   task automatic test_init();
      bit ok;
      @(negedge btn_clk); arst_n = 1'b1;
      wait_tr(2, 1000, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL init_timeout got %0d transactions want 2", tr_mosi.size()); return; end
      tests++;
      if (tr_bits[0] !== 16 || tr_mosi[0][15:0] !== 16'h3108) begin
         fails++; $display("FAIL init_fmt got %0d bits %h want 16 bits 3108", tr_bits[0], tr_mosi[0][15:0]);
      end
      tests++;
      if (tr_bits[1] !== 16 || tr_mosi[1][15:0] !== 16'h2D08) begin
         fails++; $display("FAIL init_pwr got %0d bits %h want 16 bits 2D08", tr_bits[1], tr_mosi[1][15:0]);
      end
      tests++;
      if (tr_falls[0] !== 16) begin fails++; $display("FAIL init_falls got %0d want 16", tr_falls[0]); end
      tests++;
      if ({tr_init[0], tr_init_pre[1], tr_init[1]} !== 3'b001) begin
         fails++; $display("FAIL init_done_edge got %b want 001", {tr_init[0], tr_init_pre[1], tr_init[1]});
      end
   endtask

   task automatic test_read_sample(input logic [31:0] bytes, input logic [15:0] ex, input logic [15:0] ey);
      int vc, n;
      vc = valid_cnt;
      n  = tr_mosi.size();
      slave_tx = {8'h00, bytes};
      for (int i = 0; i < PP + 500; i++) begin
         @(posedge btn_clk); #2;
         if (valid_cnt != vc) break;
      end
      tests++;
      if (valid_cnt == vc || tr_mosi.size() <= n) begin
         fails++; $display("FAIL read_timeout got %0d pulses want 1", valid_cnt - vc); return;
      end
      tests++;
      if (accel_data_x !== ex) begin fails++; $display("FAIL read_x got %h want %h", accel_data_x, ex); end
      tests++;
      if (accel_data_y !== ey) begin fails++; $display("FAIL read_y got %h want %h", accel_data_y, ey); end
      tests++;
      if (tr_mosi[n] !== 40'hF2_0000_0000 || tr_bits[n] !== 40 || tr_falls[n] !== 40) begin
         fails++; $display("FAIL read_cmd got %h/%0d bits/%0d falls want f200000000/40/40", tr_mosi[n], tr_bits[n], tr_falls[n]);
      end
      tests++;
      if (valid_delta !== 1) begin fails++; $display("FAIL valid_latency got %0d want 1", valid_delta); end
      @(posedge btn_clk); #2;
      tests++;
      if (accel_valid !== 1'b0) begin fails++; $display("FAIL valid_width got %b want 0", accel_valid); end
   endtask

   task automatic test_poll_spacing();
      tests++;
      if (read_idx.size() < 2) begin
         fails++; $display("FAIL poll_reads got %0d want 2", read_idx.size());
      end else if (tr_tfall[read_idx[1]] - tr_tfall[read_idx[0]] !== PP) begin
         fails++; $display("FAIL poll_spacing got %0d want %0d", tr_tfall[read_idx[1]] - tr_tfall[read_idx[0]], PP);
      end
   endtask

   task automatic test_hold();
      int vc;
      vc = valid_cnt;
      repeat (50) @(posedge btn_clk);
      #2;
      tests++;
      if (accel_data_x !== 16'hFFF6 || accel_data_y !== 16'h000A || valid_cnt != vc) begin
         fails++; $display("FAIL hold got %h %h pulses %0d want fff6 000a 0", accel_data_x, accel_data_y, valid_cnt - vc);
      end
   endtask

   task automatic test_reset_mid();
      int vc, n;
      bit ok, hit;
      slave_tx = {8'h00, 32'h5566_7788};
      hit = 1'b0;
      for (int i = 0; i < PP + 500; i++) begin
         @(posedge btn_clk); #2;
         if (!spi_cs_n && cur_falls == 21) begin hit = 1'b1; break; end
      end
      tests++;
      if (!hit) begin fails++; $display("FAIL mid_timeout got %0d falls want 21", cur_falls); return; end
      vc = valid_cnt;
      @(negedge btn_clk); arst_n = 1'b0;
      @(posedge btn_clk); #2;
      tests++;
      if ({spi_cs_n, accel_valid, init_done} !== 3'b100 || accel_data_x !== 16'h0 || accel_data_y !== 16'h0) begin
         fails++; $display("FAIL mid_abort got cs%b v%b i%b %h %h want cs1 v0 i0 0000 0000",
                           spi_cs_n, accel_valid, init_done, accel_data_x, accel_data_y);
      end
      repeat (3) @(posedge btn_clk);
      @(negedge btn_clk); arst_n = 1'b1;
      n = tr_mosi.size();
      wait_tr(n + 2, 1000, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL reinit_timeout got %0d want %0d", tr_mosi.size(), n + 2); return; end
      tests++;
      if (tr_mosi[n][15:0] !== 16'h3108 || tr_mosi[n+1][15:0] !== 16'h2D08 || !init_done) begin
         fails++; $display("FAIL reinit got %h %h init %b want 3108 2d08 1", tr_mosi[n][15:0], tr_mosi[n+1][15:0], init_done);
      end
      tests++;
      if (valid_cnt != vc) begin fails++; $display("FAIL mid_valid got %0d pulses want 0", valid_cnt - vc); end
   endtask

   task automatic test_protocol();
      tests++;
      if (viol_phase != 0) begin fails++; $display("FAIL sclk_phase got %0d bad phases want 0", viol_phase); end
      tests++;
      if (viol_gap != 0) begin fails++; $display("FAIL cs_gap got %0d short gaps want 0", viol_gap); end
      tests++;
      if (viol_idle != 0) begin fails++; $display("FAIL idle_lines got %0d bad samples want 0", viol_idle); end
      tests++;
      if (viol_mosi != 0) begin fails++; $display("FAIL mosi_stable got %0d bad changes want 0", viol_mosi); end
      tests++;
      if (viol_valid2 != 0) begin fails++; $display("FAIL valid_double got %0d want 0", viol_valid2); end
   endtask

   initial begin
      test_reset();
      test_init();
      test_read_sample(32'h3412_CDAB, 16'h1234, 16'hABCD);
      test_read_sample(32'hF6FF_0A00, 16'hFFF6, 16'h000A);
      test_poll_spacing();
      test_hold();
      test_reset_mid();
      test_protocol();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/accel_spi_reader.md
ACCEL_SPI_READER -- requirements
Module: accel_spi_reader

Interface
REQ-001 SHALL have parameter SCLK_HALF, default 1: btn_clk cycles per SCLK half-period (legal 1..15).
REQ-002 SHALL have parameter POLL_PERIOD, default 10000: btn_clk cycles between read starts.
REQ-003 SHALL have parameter FMT_VAL, default 8'h08: value written to DATA_FORMAT (addr 0x31), full resolution.
REQ-004 SHALL have parameter PWR_VAL, default 8'h08: value written to POWER_CTL (addr 0x2D), measure mode.
REQ-005 SHALL have port btn_clk, input, 1: sole clock, 1 MHz.
REQ-006 SHALL have port arst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port spi_cs_n, output, 1: accelerometer chip select, active-low.
REQ-008 SHALL have port spi_sclk, output, 1: SPI clock, mode 3 (idle high).
REQ-009 SHALL have port spi_mosi, output, 1: serial data to sensor, MSB first.
REQ-010 SHALL have port spi_miso, input, 1: serial data from sensor.
REQ-011 SHALL have port accel_data_x, output, 16: X sample {DATAX1, DATAX0}, two's complement.
REQ-012 SHALL have port accel_data_y, output, 16: Y sample {DATAY1, DATAY0}, two's complement.
REQ-013 SHALL have port accel_valid, output, 1: one-cycle pulse on each sample update.
REQ-014 SHALL have port init_done, output, 1: high once sensor configuration is complete.

Function
REQ-015 SHALL run FSM states INIT_FMT -> INIT_PWR -> WAIT_POLL -> READ -> UPDATE -> WAIT_POLL.
REQ-016 INIT_FMT SHALL issue one 16-bit write transaction {0x31, FMT_VAL}; INIT_PWR one {0x2D, PWR_VAL}.
REQ-017 READ SHALL issue one 40-bit transaction: command 0xF2 (read, multi-byte, addr 0x32), then 32 bits MOSI=0 while capturing MISO.
REQ-018 Transaction timing: CS_n falls with SCLK high; per bit, SCLK low SCLK_HALF cycles then high SCLK_HALF cycles.
REQ-019 MOSI SHALL change only in the cycle SCLK falls; MISO SHALL be captured in the cycle SCLK rises.
REQ-020 After last rising edge SHALL hold CS_n low SCLK_HALF further cycles, then drive CS_n high for at least 2*SCLK_HALF cycles before any next transaction.
REQ-021 Captured bytes in order X0,X1,Y0,Y1; accel_data_x={X1,X0}, accel_data_y={Y1,Y0}, no sign processing.
REQ-022 UPDATE SHALL load both outputs in the same cycle and pulse accel_valid that cycle, exactly one cycle after CS_n rises.
REQ-023 Poll timer SHALL be free-running from init_done, wrapping at POLL_PERIOD-1; wrap in WAIT_POLL starts READ.
REQ-024 Wrap occurring outside WAIT_POLL SHALL be dropped, not queued; read starts stay POLL_PERIOD-aligned.
REQ-025 init_done SHALL rise in the cycle CS_n rises after the POWER_CTL write and stay high until reset.
REQ-026 Outputs SHALL hold last value between updates; accel_valid never high for two consecutive cycles.
REQ-027 SCLK SHALL be high and MOSI low whenever CS_n is high.

Reset
REQ-028 While arst_n low at a btn_clk edge: spi_cs_n=1, spi_sclk=1, spi_mosi=0, accel_data_x=0, accel_data_y=0, accel_valid=0, init_done=0, poll timer=0, state=INIT_FMT.
REQ-029 Reset mid-transaction SHALL abort on the next edge (CS_n high), produce no accel_valid, and redo the full init sequence after release.

Verification
REQ-030 Reset release, SPI slave model -> transactions 0x31,0x08 then 0x2D,0x08; init_done=1 at second CS_n rise.
REQ-031 Read with slave bytes 34,12,CD,AB -> MOSI first byte 0xF2; accel_data_x=0x1234, accel_data_y=0xABCD, accel_valid one cycle.
REQ-032 Slave bytes F6,FF,0A,00 -> accel_data_x=0xFFF6, accel_data_y=0x000A.
REQ-033 POLL_PERIOD=10000 -> successive read CS_n falling edges exactly 10000 cycles apart; 40 SCLK falling edges each.
REQ-034 SCLK_HALF=2 -> every SCLK phase 2 cycles; CS_n high gap >=4 cycles; MOSI stable across each SCLK rise.
REQ-035 arst_n low at read bit 20 -> next edge CS_n=1, data=0, no accel_valid; after release init writes repeat.
